// File: rtl/pipe_pkg.sv
// Shared pipeline types for the ID/EX and EX/MEM stages: datapath width,
// the hard-wired zero register, and the ID/EX register layout.
package pipe_pkg;

  localparam int XLEN = 64;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            reg_write;
    logic            mem_read;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } id_ex_t;

  // True when the writeback port is really committing to register r this cycle.
  function automatic logic wb_hit(input logic en, input logic stall,
                                  input logic [4:0] wrd, input logic [4:0] r);
    return en && !stall && (wrd == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Combinational operand select: zero register, same-cycle writeback bypass,
// or the asynchronous register-file read.
module operand_bypass
  import pipe_pkg::*;
(
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            wb_en,
  input  logic            wb_stall,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] operand
);

  always_comb begin
    operand = rf_data;
    if (rs == REG_ZERO)
      operand = '0;
    else if (wb_hit(wb_en, wb_stall, wb_rd, rs))
      operand = wb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Operand fetch and ID/EX pipeline register with writeback bypass,
// load-use bubble insertion and operand refresh while EX is stalled.
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            wb_stall,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm
);

  id_ex_t          ex_q;
  id_ex_t          id_next;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            load_use;

  assign rf_rs1 = id_rs1;
  assign rf_rs2 = id_rs2;

  operand_bypass u_bypass1 (
    .rs(id_rs1), .rf_data(rf_data1), .wb_en(wb_en), .wb_stall(wb_stall),
    .wb_rd(wb_rd), .wb_data(wb_data), .operand(op1)
  );

  operand_bypass u_bypass2 (
    .rs(id_rs2), .rf_data(rf_data2), .wb_en(wb_en), .wb_stall(wb_stall),
    .wb_rd(wb_rd), .wb_data(wb_data), .operand(op2)
  );

  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != REG_ZERO) && id_valid &&
                    ((id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_q.rd)));

  assign id_stall = !flush && (ex_stall || load_use);

  // Control bits are gated by id_valid so an empty slot can never write or load.
  always_comb begin
    id_next           = '0;
    id_next.valid     = id_valid;
    id_next.rd        = id_rd;
    id_next.rs1       = id_rs1;
    id_next.rs2       = id_rs2;
    id_next.reg_write = id_valid && id_reg_write;
    id_next.mem_read  = id_valid && id_mem_read;
    id_next.rs1_val   = op1;
    id_next.rs2_val   = op2;
    id_next.pc        = id_pc;
    id_next.imm       = id_imm;
  end

  // A held instruction keeps picking up writebacks so it never executes with stale sources.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (ex_stall) begin
      if (ex_q.valid && wb_hit(wb_en, wb_stall, wb_rd, ex_q.rs1))
        ex_q.rs1_val <= wb_data;
      if (ex_q.valid && wb_hit(wb_en, wb_stall, wb_rd, ex_q.rs2))
        ex_q.rs2_val <= wb_data;
    end else if (load_use) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_next;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_rd        = ex_q.rd;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_rs1_val   = ex_q.rs1_val;
  assign ex_rs2_val   = ex_q.rs2_val;
  assign ex_pc        = ex_q.pc;
  assign ex_imm       = ex_q.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of single-cycle vectors followed by
// hand-written stall, flush and reset sequences.
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
  logic [4:0]      id_rs1, id_rs2, id_rd, rf_rs1, rf_rs2, wb_rd;
  logic [XLEN-1:0] id_pc, id_imm, rf_data1, rf_data2, wb_data;
  logic            wb_en, wb_stall, ex_stall, flush, id_stall;
  logic            ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]      ex_rd, ex_rs1, ex_rs2;
  logic [XLEN-1:0] ex_rs1_val, ex_rs2_val, ex_pc, ex_imm;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, rw, mr;
    logic [63:0] rf1, rf2;
    logic        wen, wstall;
    logic [4:0]  wrd;
    logic [63:0] wdata;
    logic        exp_stall, exp_valid;
    logic [4:0]  exp_rd;
    logic        exp_rw, exp_mr;
    logic [63:0] exp_v1, exp_v2;
    logic        chk_data;
  } vec_t;

  vec_t vecs[9];

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_pc(id_pc), .id_imm(id_imm),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_pc(ex_pc), .ex_imm(ex_imm)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic valid, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic u1, input logic u2, input logic rw, input logic mr,
    input logic [63:0] rf1, input logic [63:0] rf2,
    input logic wen, input logic wstall, input logic [4:0] wrd, input logic [63:0] wdata,
    input logic exp_stall, input logic exp_valid, input logic [4:0] exp_rd,
    input logic exp_rw, input logic exp_mr, input logic [63:0] exp_v1,
    input logic [63:0] exp_v2, input logic chk_data);
    vec_t v;
    v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.u1 = u1; v.u2 = u2; v.rw = rw; v.mr = mr; v.rf1 = rf1; v.rf2 = rf2;
    v.wen = wen; v.wstall = wstall; v.wrd = wrd; v.wdata = wdata;
    v.exp_stall = exp_stall; v.exp_valid = exp_valid; v.exp_rd = exp_rd;
    v.exp_rw = exp_rw; v.exp_mr = exp_mr; v.exp_v1 = exp_v1; v.exp_v2 = exp_v2;
    v.chk_data = chk_data;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    flush = 1'b0; ex_stall = 1'b0; reset = 1'b0;
    id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_uses_rs1 = v.u1; id_uses_rs2 = v.u2; id_reg_write = v.rw; id_mem_read = v.mr;
    rf_data1 = v.rf1; rf_data2 = v.rf2;
    wb_en = v.wen; wb_stall = v.wstall; wb_rd = v.wrd; wb_data = v.wdata;
    id_pc = 64'h1000 + 64'(idx * 4);
    id_imm = 64'(idx * 3);
  endtask

  task automatic setId(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic [63:0] pc);
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_reg_write = rw; id_mem_read = mr;
    id_pc = pc; id_imm = 64'h8;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ex_stall = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    id_pc = '0; id_imm = '0; rf_data1 = '0; rf_data2 = '0;
    wb_en = 1'b0; wb_stall = 1'b0; wb_rd = '0; wb_data = '0;

    vecs[0] = mk(1, 5, 6, 1, 1, 1, 1, 0, 64'h11, 64'h22, 1, 0, 5, 64'hABCD, 0, 1, 1, 1, 0, 64'hABCD, 64'h22, 1);
    vecs[1] = mk(1, 5, 6, 1, 1, 1, 1, 0, 64'h11, 64'h22, 1, 1, 5, 64'hABCD, 0, 1, 1, 1, 0, 64'h11, 64'h22, 1);
    vecs[2] = mk(1, 3, 0, 2, 1, 1, 1, 0, 64'h33, 64'hDEAD, 1, 0, 0, 64'hFFFF, 0, 1, 2, 1, 0, 64'h33, 64'h0, 1);
    vecs[3] = mk(1, 2, 0, 7, 1, 0, 1, 1, 64'h1000, 64'h5, 0, 0, 0, 64'h0, 0, 1, 7, 1, 1, 64'h1000, 64'h0, 1);
    vecs[4] = mk(1, 1, 7, 8, 1, 1, 1, 0, 64'h10, 64'h77, 0, 0, 0, 64'h0, 1, 0, 0, 0, 0, 64'h0, 64'h0, 0);
    vecs[5] = mk(1, 1, 7, 8, 1, 1, 1, 0, 64'h10, 64'h77, 0, 0, 0, 64'h0, 0, 1, 8, 1, 0, 64'h10, 64'h77, 1);
    vecs[6] = mk(1, 2, 0, 7, 1, 0, 1, 1, 64'h1000, 64'h5, 0, 0, 0, 64'h0, 0, 1, 7, 1, 1, 64'h1000, 64'h0, 1);
    vecs[7] = mk(1, 4, 7, 9, 1, 0, 1, 0, 64'h44, 64'h77, 0, 0, 0, 64'h0, 0, 1, 9, 1, 0, 64'h44, 64'h77, 1);
    vecs[8] = mk(0, 3, 3, 3, 1, 1, 1, 1, 64'h1, 64'h2, 0, 0, 0, 64'h0, 0, 0, 3, 0, 0, 64'h1, 64'h2, 1);

    tick();
    checkOutput("reset_valid", 64'(ex_valid), 64'h0);
    checkOutput("reset_rd", 64'(ex_rd), 64'h0);
    checkOutput("reset_rs1_val", ex_rs1_val, 64'h0);
    checkOutput("reset_pc", ex_pc, 64'h0);
    checkOutput("reset_reg_write", 64'(ex_reg_write), 64'h0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], i);
      #1;
      checkOutput($sformatf("v%0d_id_stall", i), 64'(id_stall), 64'(vecs[i].exp_stall));
      checkOutput($sformatf("v%0d_rf_rs1", i), 64'(rf_rs1), 64'(vecs[i].rs1));
      tick();
      checkOutput($sformatf("v%0d_valid", i), 64'(ex_valid), 64'(vecs[i].exp_valid));
      checkOutput($sformatf("v%0d_reg_write", i), 64'(ex_reg_write), 64'(vecs[i].exp_rw));
      checkOutput($sformatf("v%0d_mem_read", i), 64'(ex_mem_read), 64'(vecs[i].exp_mr));
      if (vecs[i].chk_data) begin
        checkOutput($sformatf("v%0d_rd", i), 64'(ex_rd), 64'(vecs[i].exp_rd));
        checkOutput($sformatf("v%0d_rs1_val", i), ex_rs1_val, vecs[i].exp_v1);
        checkOutput($sformatf("v%0d_rs2_val", i), ex_rs2_val, vecs[i].exp_v2);
        checkOutput($sformatf("v%0d_pc", i), ex_pc, 64'h1000 + 64'(i * 4));
      end
    end

    // Hold refresh across a three-cycle EX stall.
    wb_en = 1'b0; wb_stall = 1'b0;
    setId(9, 10, 11, 1, 0, 64'h200);
    rf_data1 = 64'h90; rf_data2 = 64'hA0;
    tick();
    checkOutput("hold_capture", ex_rs1_val, 64'h90);
    setId(1, 2, 3, 1, 1, 64'h999);
    rf_data1 = 64'hBAD1; rf_data2 = 64'hBAD2;
    ex_stall = 1'b1;
    wb_en = 1'b1; wb_stall = 1'b1; wb_rd = 10; wb_data = 64'h77;
    #1;
    checkOutput("hold_id_stall", 64'(id_stall), 64'h1);
    tick();
    wb_stall = 1'b0; wb_rd = 9; wb_data = 64'h55;
    tick();
    wb_en = 1'b0;
    tick();
    ex_stall = 1'b0;
    checkOutput("hold_rs1_val", ex_rs1_val, 64'h55);
    checkOutput("hold_rs2_val", ex_rs2_val, 64'hA0);
    checkOutput("hold_rd", 64'(ex_rd), 64'd11);
    checkOutput("hold_rs1", 64'(ex_rs1), 64'd9);
    checkOutput("hold_pc", ex_pc, 64'h200);
    checkOutput("hold_imm", ex_imm, 64'h8);
    checkOutput("hold_valid", 64'(ex_valid), 64'h1);
    checkOutput("hold_mem_read", 64'(ex_mem_read), 64'h0);

    // Flush beats both ex_stall and a pending load-use hazard.
    setId(2, 0, 7, 1, 1, 64'h300);
    tick();
    checkOutput("flush_load_in_ex", 64'(ex_mem_read), 64'h1);
    setId(7, 0, 8, 1, 0, 64'h304);
    ex_stall = 1'b1;
    #1;
    checkOutput("flush_pre_stall", 64'(id_stall), 64'h1);
    ex_stall = 1'b0;
    #1;
    checkOutput("flush_pre_load_use", 64'(id_stall), 64'h1);
    ex_stall = 1'b1;
    flush = 1'b1;
    #1;
    checkOutput("flush_id_stall", 64'(id_stall), 64'h0);
    tick();
    checkOutput("flush_valid", 64'(ex_valid), 64'h0);
    checkOutput("flush_mem_read", 64'(ex_mem_read), 64'h0);
    flush = 1'b0; ex_stall = 1'b0;

    // Reset in the middle of a stall clears EX.
    setId(3, 4, 5, 1, 0, 64'h400);
    rf_data1 = 64'h123; rf_data2 = 64'h456;
    tick();
    checkOutput("rst_pre_valid", 64'(ex_valid), 64'h1);
    ex_stall = 1'b1; reset = 1'b1;
    tick();
    checkOutput("rst_valid", 64'(ex_valid), 64'h0);
    checkOutput("rst_rd", 64'(ex_rd), 64'h0);
    checkOutput("rst_rs1_val", ex_rs1_val, 64'h0);
    checkOutput("rst_rs2_val", ex_rs2_val, 64'h0);
    checkOutput("rst_pc", ex_pc, 64'h0);
    checkOutput("rst_imm", ex_imm, 64'h0);
    checkOutput("rst_reg_write", 64'(ex_reg_write), 64'h0);
    checkOutput("rst_id_stall", 64'(id_stall), 64'h1);
    reset = 1'b0; ex_stall = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
